// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types and the fetch-stage state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RESET  = 2'd0,
    REQ    = 2'd1,
    SQUASH = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  localparam word_t WORD_INC = 32'd4;

  // Instruction addresses are always word aligned; low bits are dropped.
  function automatic word_t word_align(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Signal bundle between fetch, decode and instruction memory.
interface fetch_unit_if;
  import cpu_types_pkg::*;

  logic  ihit;
  word_t imemload;
  logic  imemREN;
  word_t imemaddr;
  logic  stall;
  logic  redirect;
  word_t redirect_pc;
  logic  halt;
  word_t instr;
  word_t npc;
  logic  instr_valid;
  logic  halted;

  modport fetch (
    input  ihit, imemload, stall, redirect, redirect_pc, halt,
    output imemREN, imemaddr, instr, npc, instr_valid, halted
  );

  modport decode (
    input  instr, npc, instr_valid, halted,
    output stall, redirect, redirect_pc, halt
  );

  modport tb (
    input  imemREN, imemaddr, instr, npc, instr_valid, halted,
    output ihit, imemload, stall, redirect, redirect_pc, halt
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues held imem reads and fills
// the IF/ID latch.
//
//   state  | meaning
//   RESET  | one idle cycle after reset, no imem request
//   REQ    | requesting imem at pc; accepts hits, stalls, redirects
//   SQUASH | redirect arrived mid-read; hold address, drop data, then jump
//   HALTED | fetch stopped for good until reset
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] instr,
  output logic [31:0] npc,
  output logic        instr_valid,
  output logic        halted
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        pend_pc_q, pend_pc_d;
  word_t        instr_q, instr_d;
  word_t        npc_q, npc_d;
  logic         instr_valid_q, instr_valid_d;

  word_t pc_inc;
  word_t redir_tgt;

  assign pc_inc    = pc_q + WORD_INC;
  assign redir_tgt = word_align(redirect_pc);

  // Next-state and IF/ID update; halt beats redirect beats stall beats ihit.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_pc_d     = pend_pc_q;
    instr_d       = instr_q;
    npc_d         = npc_q;
    instr_valid_d = instr_valid_q;

    unique case (state_q)
      RESET: begin
        state_d = REQ;
      end
      REQ: begin
        if (halt) begin
          state_d       = HALTED;
          instr_valid_d = 1'b0;
        end else if (redirect) begin
          instr_valid_d = 1'b0;
          if (ihit) begin
            pc_d = redir_tgt;
          end else begin
            pend_pc_d = redir_tgt;
            state_d   = SQUASH;
          end
        end else if (stall) begin
          // IF/ID and pc hold so decode sees the same instruction again.
        end else if (ihit) begin
          instr_d       = imemload;
          npc_d         = pc_inc;
          instr_valid_d = 1'b1;
          pc_d          = pc_inc;
        end else begin
          instr_valid_d = 1'b0;
        end
      end
      SQUASH: begin
        instr_valid_d = 1'b0;
        if (halt) begin
          state_d = HALTED;
        end else if (ihit) begin
          // The outstanding read is complete; its data is discarded.
          pc_d    = redirect ? redir_tgt : pend_pc_q;
          state_d = REQ;
        end else if (redirect) begin
          pend_pc_d = redir_tgt;
        end
      end
      HALTED: begin
        instr_valid_d = 1'b0;
      end
      default: begin
        state_d = RESET;
      end
    endcase
  end

  // State and IF/ID registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= RESET;
      pc_q          <= word_align(PC_INIT);
      pend_pc_q     <= '0;
      instr_q       <= '0;
      npc_q         <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_pc_q     <= pend_pc_d;
      instr_q       <= instr_d;
      npc_q         <= npc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imemREN     = (state_q == REQ) || (state_q == SQUASH);
  assign imemaddr    = pc_q;
  assign instr       = instr_q;
  assign npc         = npc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = (state_q == HALTED);

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the decode/control unit. Owns the program counter, issues word reads to instruction memory with a hold-until-hit handshake, and registers each fetched instruction with its PC+4 into the IF/ID latch that decode reads. Accepts PC redirects (jump, JR, taken branch) and the decode-side halt, squashing in-flight fetches as required.

## Interface
Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset

Ports:
- CLK  in  1  clock; all state updates on rising edge
- nRST  in  1  reset, asynchronous, active-low
- ihit  in  1  imem response valid for current imemaddr this cycle
- imemload  in  32  instruction word returned by imem
- imemREN  out  1  imem read enable
- imemaddr  out  32  imem word address (= PC register, bits [1:0] always 00)
- stall  in  1  decode cannot accept a new instruction this cycle
- redirect  in  1  load redirect_pc as next fetch address; flush IF/ID
- redirect_pc  in  32  redirect target (bits [1:0] ignored, forced 00)
- halt  in  1  decode has a HALT in IF/ID
- instr  out  32  IF/ID instruction
- npc  out  32  IF/ID PC+4 of instr (JAL link / branch base)
- instr_valid  out  1  IF/ID holds a real instruction
- halted  out  1  fetch permanently stopped (sticky until reset)

## Operation
- FSM states: RESET, REQ, SQUASH, HALTED. Registers: pc, pend_pc, instr, npc, instr_valid.
- Reset (nRST low, any cycle, mid-request included): state=RESET, pc=PC_INIT, pend_pc=0, instr=0, npc=0, instr_valid=0, halted=0, imemREN=0.
- RESET: imemREN=0; next state REQ unconditionally.
- REQ: imemREN=1, imemaddr=pc. Priority per cycle: halt > redirect > stall > ihit.
  - halt: -> HALTED, instr_valid<=0.
  - redirect & ihit: pc<=redirect_pc, instr_valid<=0, stay REQ.
  - redirect & !ihit: pend_pc<=redirect_pc, instr_valid<=0, -> SQUASH (address held stable until outstanding read completes).
  - stall: pc, instr, npc, instr_valid all hold; imemREN stays 1.
  - ihit: instr<=imemload, npc<=pc+4, instr_valid<=1, pc<=pc+4.
  - none: instr_valid<=0 (bubble), pc holds.
- SQUASH: imemREN=1, imemaddr=pc (old). On ihit: data discarded, pc<=pend_pc, -> REQ. A second redirect overwrites pend_pc. halt -> HALTED. instr_valid stays 0.
- HALTED: imemREN=0, halted=1, instr_valid=0; no exit except reset. All inputs ignored.
- Arithmetic: pc+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0.
- Redirect during stall flushes: stall does not protect IF/ID from redirect.

## Timing
- Fetch latency: one cycle from ihit to instr/instr_valid visible at decode.
- Back-to-back: with ihit every cycle and no stall, one instruction per cycle; first valid instr on 2nd edge after nRST rises (RESET cycle + REQ cycle).
- Redirect: target address on imemaddr the cycle after redirect if ihit coincident; otherwise the cycle after the pending ihit in SQUASH.
- halted asserts the cycle after halt sampled in REQ/SQUASH; imemREN drops same cycle.
- imemaddr must not change while imemREN=1 and ihit=0.

## Structure
- word_t (32-bit) from cpu_types_pkg; add fetch_state_t enum (RESET, REQ, SQUASH, HALTED) and WORD_INC = 32'd4 to cpu_types_pkg.
- Interface bundle fetch_unit_if with modports fetch / decode / tb, matching the control_unit_if style.
- Single module, no sub-modules; next-state and output logic combinational, one always_ff with async nRST.

## Test plan
- Reset, ihit tied 1, imem returns addr-as-data: instr = 0,4,8,C on consecutive cycles, npc = 4,8,C,10, imemREN=0 during RESET cycle.
- ihit low 3 cycles at pc=0x10: imemaddr stays 0x10, instr_valid=0 those cycles, then instr=mem[0x10], npc=0x14.
- stall high 2 cycles with ihit=1 at pc=0x20: instr/npc/pc frozen, then resumes at 0x20 with no duplication or skip.
- redirect to 0x103 with ihit=0 at pc=0x40: imemaddr holds 0x40 until ihit, that data dropped (instr_valid=0), next imemaddr=0x100.
- halt with simultaneous redirect: HALTED entered, halted=1, imemREN=0 permanently; nRST pulse mid-HALTED returns pc=PC_INIT, halted=0.
- pc=0xFFFF_FFFC with ihit: npc=0, next imemaddr=0.
